// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_detector_pkg;

  typedef enum logic [1:0] {IDLE, FILL, ARMED} sd_state_t;

  // Width needed to count 0..pat_w accepted bits.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= &cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: shifts in qualified bits and pulses match when the
// last PAT_W accepted bits equal PATTERN; keeps a saturating hit count.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  logic             din,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             busy
);

  localparam int               FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  sd_state_t         state_q;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q;
  logic              acc, hit, flush_on_hit;

  assign acc    = en & valid_in & ~clear;
  assign hist_d = {hist_q[PAT_W-2:0], din};
  assign fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  assign hit    = acc & (fill_d == FILL_FULL) & (hist_d == PATTERN);
  // Non-overlapping mode restarts the search from scratch after every hit.
  assign flush_on_hit = hit & ~OVERLAP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (!en) begin
        state_q <= IDLE;
        hist_q  <= '0;
        fill_q  <= '0;
      end else if (clear) begin
        state_q <= FILL;
        hist_q  <= '0;
        fill_q  <= '0;
      end else begin
        if (acc) begin
          hist_q <= flush_on_hit ? '0 : hist_d;
          fill_q <= flush_on_hit ? '0 : fill_d;
        end
        unique case (state_q)
          IDLE:    state_q <= FILL;
          FILL:    if (acc && (fill_d == FILL_FULL) && !flush_on_hit) state_q <= ARMED;
          ARMED:   if (flush_on_hit) state_q <= FILL;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (hit),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  assign match = match_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: overlap, non-overlap and saturating
// instances share one stimulus stream.
module tb_seq_detector;

  logic clk = 1'b0;
  logic rst, en, valid_in, din, clear;

  logic       m_ov, sat_ov, busy_ov;
  logic [7:0] c_ov;
  logic       m_nov, sat_nov, busy_nov;
  logic [7:0] c_nov;
  logic       m_sat, sat_sat, busy_sat;
  logic [1:0] c_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .din(din), .clear(clear),
    .match(m_ov), .match_cnt(c_ov), .cnt_sat(sat_ov), .busy(busy_ov));

  seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .din(din), .clear(clear),
    .match(m_nov), .match_cnt(c_nov), .cnt_sat(sat_nov), .busy(busy_nov));

  seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .din(din), .clear(clear),
    .match(m_sat), .match_cnt(c_sat), .cnt_sat(sat_sat), .busy(busy_sat));

  typedef struct {
    logic       en, valid, din, clr;
    logic       m_ov;
    logic [7:0] c_ov;
    logic       m_nov;
    logic [7:0] c_nov;
    logic       busy;
  } vec_t;

  vec_t tbl[8];
  int   bits[7];
  int   exp_m_ov[7], exp_c_ov[7], exp_m_nov[7], exp_c_nov[7];
  int   sat_cnt_exp[4], sat_flag_exp[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 ns after the edge.
  task automatic apply(input logic e, input logic v, input logic d, input logic c);
    en = e; valid_in = v; din = d; clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid_in = 1'b0; din = 1'b0; clear = 1'b0;

    bits      = '{1, 0, 1, 1, 0, 1, 1};
    exp_m_ov  = '{0, 0, 0, 1, 0, 0, 1};
    exp_c_ov  = '{0, 0, 0, 1, 1, 1, 2};
    exp_m_nov = '{0, 0, 0, 1, 0, 0, 0};
    exp_c_nov = '{0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++)
      tbl[i] = '{1'b1, 1'b1, 1'(bits[i]), 1'b0, 1'(exp_m_ov[i]), 8'(exp_c_ov[i]),
                 1'(exp_m_nov[i]), 8'(exp_c_nov[i]), 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1};
    sat_cnt_exp  = '{1, 2, 3, 3};
    sat_flag_exp = '{0, 0, 1, 1};

    #2;
    check("rst_match", {31'd0, m_ov}, 32'd0);
    check("rst_cnt",   {24'd0, c_ov}, 32'd0);
    check("rst_sat",   {31'd0, sat_ov}, 32'd0);
    check("rst_busy",  {31'd0, busy_ov}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream on both overlap modes, then a clear.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].en, tbl[i].valid, tbl[i].din, tbl[i].clr);
      check($sformatf("tbl%0d_m_ov", i),  {31'd0, m_ov},  {31'd0, tbl[i].m_ov});
      check($sformatf("tbl%0d_c_ov", i),  {24'd0, c_ov},  {24'd0, tbl[i].c_ov});
      check($sformatf("tbl%0d_m_nov", i), {31'd0, m_nov}, {31'd0, tbl[i].m_nov});
      check($sformatf("tbl%0d_c_nov", i), {24'd0, c_nov}, {24'd0, tbl[i].c_nov});
      check($sformatf("tbl%0d_busy", i),  {30'd0, busy_ov, busy_nov}, {30'd0, tbl[i].busy, tbl[i].busy});
    end

    // Same stream with two idle cycles after every bit.
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b1, 1'(bits[i]), 1'b0);
      check($sformatf("gap%0d_m_ov", i),  {31'd0, m_ov},  32'(exp_m_ov[i]));
      check($sformatf("gap%0d_m_nov", i), {31'd0, m_nov}, 32'(exp_m_nov[i]));
      for (int g = 0; g < 2; g++) begin
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        check($sformatf("gap%0d_%0d_m_ov", i, g), {30'd0, m_ov, m_nov}, 32'd0);
        check($sformatf("gap%0d_%0d_c_ov", i, g), {24'd0, c_ov}, 32'(exp_c_ov[i]));
        check($sformatf("gap%0d_%0d_c_nov", i, g), {24'd0, c_nov}, 32'(exp_c_nov[i]));
      end
    end

    // Saturation on the 2-bit counter: 1011 four times.
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        apply(1'b1, 1'b1, 1'(bits[b]), 1'b0);
        if (b == 3) begin
          check($sformatf("sat%0d_match", r), {31'd0, m_sat}, 32'd1);
          check($sformatf("sat%0d_cnt", r),   {30'd0, c_sat}, 32'(sat_cnt_exp[r]));
          check($sformatf("sat%0d_flag", r),  {31'd0, sat_sat}, 32'(sat_flag_exp[r]));
        end
      end
    end

    // Async reset between edges with a partial pattern pending.
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("prerst_cnt", {24'd0, c_ov}, 32'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_cnt",  {24'd0, c_ov}, 32'd0);
    check("arst_busy", {31'd0, busy_ov}, 32'd0);
    check("arst_sat",  {31'd0, sat_sat}, 32'd0);
    #1 rst = 1'b0;
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("arst_after1_m", {31'd0, m_ov}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 1'(bits[i]), 1'b0);
      check($sformatf("arst_seq%0d_m", i), {31'd0, m_ov}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("arst_seq_cnt", {24'd0, c_ov}, 32'd1);

    // clear together with a valid bit that would otherwise complete 1011.
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_match", {31'd0, m_ov}, 32'd0);
    check("clr_cnt",   {24'd0, c_ov}, 32'd0);
    check("clr_busy",  {31'd0, busy_ov}, 32'd1);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_next_m", {31'd0, m_ov}, 32'd0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_resume_m", {31'd0, m_ov}, 32'd1);

    // en dropped for one cycle with 1,0,1 pending.
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0);
    check("endrop_busy",  {31'd0, busy_ov}, 32'd0);
    check("endrop_match", {31'd0, m_ov}, 32'd0);
    check("endrop_cnt",   {24'd0, c_ov}, 32'd1);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("enback_match", {31'd0, m_ov}, 32'd0);
    check("enback_busy",  {31'd0, busy_ov}, 32'd1);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("enback_hit", {31'd0, m_ov}, 32'd1);
    check("enback_cnt", {24'd0, c_ov}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
Parametrised serial pattern-detector FSM, the successor to the team's fixed 5-state x/y test FSM. It samples a qualified serial bit stream and compares the last PAT_W accepted bits against a compile-time PATTERN. On a hit it raises a one-cycle pulse. Overlapping or non-overlapping detection is selectable, and a saturating hit counter is maintained. It sits behind serial front-ends as a framing/sync-word detector.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1011, PAT_W-bit reference; PATTERN[PAT_W-1] is compared against the oldest bit.
CNT_W, 8, width of the hit counter.
OVERLAP, 1, 1 = history is kept after a hit; 0 = history is flushed after a hit.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  detector enable.
valid_in  input  1  din is valid this cycle.
din  input  1  serial data bit.
clear  input  1  synchronous flush of history and counter.
match  output  1  one-cycle hit pulse.
match_cnt  output  CNT_W  saturating hit count.
cnt_sat  output  1  high while match_cnt is all-ones.
busy  output  1  high when state is not IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, hist=0, fill=0, match=0, match_cnt=0, cnt_sat=0, busy=0.
- Accept condition: acc = en & valid_in & ~clear. Nothing is sampled when acc=0.
- History update on acc: hist <= {hist[PAT_W-2:0], din}. Newest bit is the LSB.
- Fill count on acc: fill <= min(fill+1, PAT_W).
- Hit: hit = acc & (fill_next == PAT_W) & ({hist[PAT_W-2:0], din} == PATTERN).
- match is registered: it is high exactly in the cycle after the accepting edge of the PAT_W-th matching bit. It is never high for two cycles unless two consecutive accepted bits each complete a hit, which is possible only with OVERLAP=1 and a periodic pattern.
- On hit with OVERLAP=0: hist <= 0 and fill <= 0. This overrides the normal update.
- On hit with OVERLAP=1: normal update.
- match_cnt: increments on hit and holds at 2^CNT_W-1. cnt_sat = &match_cnt, registered with match_cnt.
- FSM states and transitions:
  - IDLE -> FILL when en=1.
  - FILL -> ARMED when fill_next == PAT_W.
  - ARMED -> FILL on a hit with OVERLAP=0.
  - Any state -> IDLE on en=0.
- en=0: next state is IDLE, fill <= 0, hist <= 0. match_cnt is retained. match is forced to 0 from the next cycle.
- clear=1: hist, fill and match_cnt <= 0. match <= 0 next cycle. State becomes FILL if en=1, otherwise IDLE. clear beats valid_in in the same cycle.
- rst mid-stream: all state is lost immediately. A partial pattern never completes across a reset.
- busy = (state != IDLE), decoded combinationally from the state register.

Decomposition:
- Package seq_detector_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, ARMED} sd_state_t;
  - localparam function clog2-based FILL_W = $clog2(PAT_W+1).
- One sub-module, sat_counter:
  - parameter W;
  - ports clk, rst, clr, inc, cnt, sat.
  - Used for match_cnt and cnt_sat.
- FSM, history and compare stay in the top.

Test Plan:
- Overlap, back-to-back: defaults (PAT_W=4, PATTERN=1011, OVERLAP=1), en=1, valid_in=1, din 1,0,1,1,0,1,1 -> match pulses in the cycles after bits 4 and 7; match_cnt=2; busy=1.
- Non-overlap: OVERLAP=0, same stream -> match only after bit 4; match_cnt=1; state returns to FILL for bits 5-7.
- Gapped valid: same stream as the first scenario with valid_in=0 for 2 cycles between every bit -> identical hit count (2). Each pulse is exactly 1 cycle, one cycle after the 4th and 7th accepted bits.
- Saturation: CNT_W=2, stream 1011 repeated 4 times (OVERLAP=1) -> match_cnt goes 1,2,3,3; cnt_sat=1 from the third hit onward.
- Async reset mid-pattern: send 1,0,1, pulse rst asynchronously between clock edges, then send 1 -> outputs reset immediately and no match. Then send 1,0,1,1 -> a single match.
- clear/en: send 1,0,1, assert clear together with din=1 & valid_in -> no match and match_cnt=0. Repeat with en dropped for 1 cycle instead -> busy=0 for one cycle, history discarded, no match.
